// File: rtl/router_merge_arb_if.sv
// Handshake bundle for router_merge_arb. Two 4-phase requesters (A, B) are merged
// onto one 4-phase output channel. The counter and source flag ride along.
interface router_merge_arb_if #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned CNT_W = 8
);
   logic             a_req;
   logic [WIDTH-1:0] a_data;
   logic             a_ack;
   logic             b_req;
   logic [WIDTH-1:0] b_data;
   logic             b_ack;
   logic             o_req;
   logic [WIDTH-1:0] o_data;
   logic             o_ack;
   logic             o_src;
   logic [CNT_W-1:0] pkt_cnt;

   // Arbiter side.
   modport slave (
      input  a_req, a_data, b_req, b_data, o_ack,
      output a_ack, b_ack, o_req, o_data, o_src, pkt_cnt
   );

   // Requesters and downstream side.
   modport master (
      output a_req, a_data, b_req, b_data, o_ack,
      input  a_ack, b_ack, o_req, o_data, o_src, pkt_cnt
   );
endinterface

// File: rtl/router_merge_arb.sv
// Two-input 4-phase merge arbiter. It alternates on contention, forwards one packet
// at a time to a shared 4-phase output and counts completed transfers.
module router_merge_arb #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned CNT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   router_merge_arb_if.slave io_bus
);
   typedef enum logic [1:0] {StIdle, StOutReq, StOutRtz, StInAck} state_e;

   state_e           r_state, w_state_d;
   logic             r_last_grant, w_last_grant_d;  // 1 = B was served last
   logic             r_src, w_src_d;
   logic [WIDTH-1:0] r_data, w_data_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d;
   logic             r_o_req, w_o_req_d;
   logic             r_a_ack, w_a_ack_d;
   logic             r_b_ack, w_b_ack_d;
   logic             w_sel;
   logic             w_sel_req;

   // On contention the requester not served last wins.
   assign w_sel     = (io_bus.a_req && io_bus.b_req) ? ~r_last_grant : io_bus.b_req;
   assign w_sel_req = r_src ? io_bus.b_req : io_bus.a_req;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= StIdle;
         r_last_grant <= 1'b1;
         r_src        <= 1'b0;
         r_data       <= '0;
         r_cnt        <= '0;
         r_o_req      <= 1'b0;
         r_a_ack      <= 1'b0;
         r_b_ack      <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_last_grant <= w_last_grant_d;
         r_src        <= w_src_d;
         r_data       <= w_data_d;
         r_cnt        <= w_cnt_d;
         r_o_req      <= w_o_req_d;
         r_a_ack      <= w_a_ack_d;
         r_b_ack      <= w_b_ack_d;
      end
   end

   always_comb begin
      w_state_d      = r_state;
      w_last_grant_d = r_last_grant;
      w_src_d        = r_src;
      w_data_d       = r_data;
      w_cnt_d        = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (io_bus.a_req || io_bus.b_req) begin
               w_state_d = StOutReq;
               w_src_d   = w_sel;
               w_data_d  = w_sel ? io_bus.b_data : io_bus.a_data;
            end
         end
         StOutReq: begin
            if (io_bus.o_ack) w_state_d = StOutRtz;
         end
         StOutRtz: begin
            if (!io_bus.o_ack) w_state_d = StInAck;
         end
         StInAck: begin
            if (!w_sel_req) begin
               w_state_d      = StIdle;
               w_last_grant_d = r_src;
               w_cnt_d        = r_cnt + 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so they leave flops directly.
   always_comb begin
      w_o_req_d = (w_state_d == StOutReq);
      w_a_ack_d = (w_state_d == StInAck) && !w_src_d;
      w_b_ack_d = (w_state_d == StInAck) &&  w_src_d;
   end

   assign io_bus.o_req   = r_o_req;
   assign io_bus.a_ack   = r_a_ack;
   assign io_bus.b_ack   = r_b_ack;
   assign io_bus.o_data  = r_data;
   assign io_bus.o_src   = r_src;
   assign io_bus.pkt_cnt = r_cnt;
endmodule

// File: tb/tb_router_merge_arb.sv
// Randomized scoreboard bench for router_merge_arb: rounds of 4-phase requests are
// predicted into a queue and a monitor checks every forwarded packet and completion.
module tb_router_merge_arb;
   localparam int unsigned WIDTH = 11;
   localparam int unsigned CNT_W = 8;
   localparam int          TMO   = 400;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             src;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   router_merge_arb_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   router_merge_arb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        exp_q[$];
   logic        m_last_grant;
   int unsigned m_cnt;
   int unsigned m_total;
   bit          auto_resp;
   int          resp_fix;
   bit          saw_wrap;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic void model_reset();
      m_last_grant = 1'b1;
      m_cnt        = 0;
      m_total      = 0;
      exp_q.delete();
   endfunction

   // Transfers complete in grant order, so the count after each is known at push time.
   function automatic void push(input logic src, input logic [WIDTH-1:0] data);
      exp_t e;
      m_cnt        = (m_cnt + 1) % (1 << CNT_W);
      m_total      = m_total + 1;
      m_last_grant = src;
      e.data       = data;
      e.src        = src;
      e.cnt        = m_cnt[CNT_W-1:0];
      exp_q.push_back(e);
   endfunction

   task automatic wait_oreq(input logic val, input string name);
      int t;
      t = 0;
      while (bus.o_req !== val && t < TMO) begin
         @(negedge clk);
         t++;
      end
      if (t >= TMO) check(name, 32'(bus.o_req), 32'(val));
   endtask

   task automatic requester(input logic src, input logic [WIDTH-1:0] data);
      int t;
      if (src) begin
         bus.b_data = data;
         bus.b_req  = 1'b1;
      end else begin
         bus.a_data = data;
         bus.a_req  = 1'b1;
      end
      t = 0;
      while ((src ? bus.b_ack : bus.a_ack) !== 1'b1 && t < TMO) begin
         @(negedge clk);
         t++;
      end
      if (t >= TMO) check(src ? "b_ack_rise_timeout" : "a_ack_rise_timeout", 0, 1);
      if (src) bus.b_req = 1'b0;
      else     bus.a_req = 1'b0;
      t = 0;
      while ((src ? bus.b_ack : bus.a_ack) !== 1'b0 && t < TMO) begin
         @(negedge clk);
         t++;
      end
      if (t >= TMO) check(src ? "b_ack_fall_timeout" : "a_ack_fall_timeout", 1, 0);
      if (src) bus.b_data = WIDTH'($urandom);
      else     bus.a_data = WIDTH'($urandom);
   endtask

   // kind 0: A only, 1: B only, 2: both together, 3/4: A/B first, the other arrives late.
   task automatic round(input int kind, input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
      logic f;
      case (kind)
         0: begin
            push(1'b0, da);
            requester(1'b0, da);
         end
         1: begin
            push(1'b1, db);
            requester(1'b1, db);
         end
         2: begin
            if (m_last_grant) begin
               push(1'b0, da);
               push(1'b1, db);
            end else begin
               push(1'b1, db);
               push(1'b0, da);
            end
            fork
               requester(1'b0, da);
               requester(1'b1, db);
            join
         end
         default: begin
            f = (kind == 4);
            push(f, f ? db : da);
            push(!f, f ? da : db);
            fork
               requester(f, f ? db : da);
               begin
                  wait_oreq(1'b1, "o_req_rise_timeout");
                  requester(!f, f ? da : db);
               end
            join
         end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_o_req"},   32'(bus.o_req),   0);
      check({tag, "_a_ack"},   32'(bus.a_ack),   0);
      check({tag, "_b_ack"},   32'(bus.b_ack),   0);
      check({tag, "_o_data"},  32'(bus.o_data),  0);
      check({tag, "_o_src"},   32'(bus.o_src),   0);
      check({tag, "_pkt_cnt"}, 32'(bus.pkt_cnt), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin : responder
      int               d;
      int               t;
      logic [WIDTH-1:0] held;
      bus.o_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (auto_resp && bus.o_req === 1'b1) begin
            d    = (resp_fix >= 0) ? resp_fix : int'($urandom_range(0, 4));
            held = bus.o_data;
            repeat (d) begin
               @(negedge clk);
               check("o_req_hold", 32'(bus.o_req), 1);
               check("o_data_hold", 32'(bus.o_data), 32'(held));
            end
            bus.o_ack = 1'b1;
            t = 0;
            while (bus.o_req !== 1'b0 && t < TMO) begin
               @(negedge clk);
               t++;
            end
            if (t >= TMO) check("o_req_fall_timeout", 1, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus.o_ack = 1'b0;
         end
      end
   end

   initial begin : monitor
      logic             p_oreq, p_aack, p_back;
      logic [CNT_W-1:0] p_cnt;
      exp_t             cur;
      bit               cur_valid;
      p_oreq = 1'b0; p_aack = 1'b0; p_back = 1'b0; p_cnt = '0; cur_valid = 1'b0;
      cur = '0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            cur_valid = 1'b0;
         end else begin
            if (bus.o_req === 1'b1 && p_oreq !== 1'b1) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_transfer", 1, 0);
               end else begin
                  cur       = exp_q.pop_front();
                  cur_valid = 1'b1;
                  check("o_data", 32'(bus.o_data), 32'(cur.data));
                  check("o_src", 32'(bus.o_src), 32'(cur.src));
               end
            end
            if (bus.a_ack === 1'b1 || bus.b_ack === 1'b1) begin
               check("ack_exclusive", 32'(bus.a_ack & bus.b_ack), 0);
               check("ack_while_downstream_busy", 32'(bus.o_req | bus.o_ack), 0);
               if (cur_valid) check("ack_owner", 32'(bus.b_ack), 32'(cur.src));
            end
            if ((p_aack === 1'b1 && bus.a_ack === 1'b0) ||
                (p_back === 1'b1 && bus.b_ack === 1'b0)) begin
               check("pkt_cnt", 32'(bus.pkt_cnt), 32'(cur.cnt));
               check("idle_gap", 32'(bus.o_req), 0);
               if (p_cnt == '1 && bus.pkt_cnt == '0) saw_wrap = 1'b1;
               cur_valid = 1'b0;
            end
         end
         p_oreq = bus.o_req;
         p_aack = bus.a_ack;
         p_back = bus.b_ack;
         p_cnt  = bus.pkt_cnt;
      end
   end

   initial begin : stim
      logic [WIDTH-1:0] d;
      reset      = 1'b0;
      bus.a_req  = 1'b0;
      bus.b_req  = 1'b0;
      bus.a_data = '0;
      bus.b_data = '0;
      auto_resp  = 1'b1;
      resp_fix   = -1;
      saw_wrap   = 1'b0;
      model_reset();

      do_reset();
      round(0, 11'h2A5, 11'h0);
      check("single_a_pkt_cnt", 32'(bus.pkt_cnt), 1);

      // Contention right after reset: A, B, A, B.
      do_reset();
      round(2, 11'h001, 11'h400);
      round(2, 11'h001, 11'h400);
      check("alternate_pkt_cnt", 32'(bus.pkt_cnt), 4);

      round(3, WIDTH'($urandom), WIDTH'($urandom));
      round(4, WIDTH'($urandom), WIDTH'($urandom));

      resp_fix = 10;
      round(0, 11'h7FF, 11'h0);
      round(1, 11'h0, 11'h5A3);
      resp_fix = -1;

      // Reset while waiting for the downstream acknowledge to return to zero.
      auto_resp = 1'b0;
      d = 11'h6C3;
      push(1'b0, d);
      bus.a_data = d;
      bus.a_req  = 1'b1;
      wait_oreq(1'b1, "rtz_o_req_rise_timeout");
      @(negedge clk);
      bus.o_ack = 1'b1;
      wait_oreq(1'b0, "rtz_o_req_fall_timeout");
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("midop");
      bus.a_req = 1'b0;
      bus.o_ack = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      auto_resp = 1'b1;
      @(negedge clk);
      round(2, 11'h0F0, 11'h70F);
      check("after_midop_pkt_cnt", 32'(bus.pkt_cnt), 2);

      while (m_total < 300) begin
         round(int'($urandom_range(0, 4)), WIDTH'($urandom), WIDTH'($urandom));
      end
      check("counter_wrapped", 32'(saw_wrap), 1);
      check("final_pkt_cnt", 32'(bus.pkt_cnt), 32'(m_cnt));
      check("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
